sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer; the receive end for the 8-bit parallel register path. It assembles a qualified serial bit stream into WIDTH-bit words. Each completed word is presented through a one-word holding register with a valid/ready handshake. An optional sync strobe aligns word boundaries. It sits between a serial link front end and the byte-wide datapath.

---
 rtl/sipo_pkg.sv | 9 +
 rtl/sipo_shifter.sv | 39 +++
 rtl/sipo_deser.sv | 39 +++
 tb/tb_sipo_deser.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and helpers for the sipo_deser deserializer
package sipo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam bit MSB_FIRST_ENC = 1'b1;
  localparam bit LSB_FIRST_ENC = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/sipo_shifter.sv
// sipo_shifter: shift register and bit counter with sync alignment; flags word completion
module sipo_shifter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ENC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] sh;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  // word is the shift value including the bit accepted on this edge
  assign word = MSB_FIRST ? {sh[WIDTH-2:0], sin} : {sin, sh[WIDTH-1:1]};
  assign done = sin_valid & ~sync & last;
  always_comb
    cnt_nxt = sync ? (sin_valid ? CW'(1) : '0)
            : sin_valid ? (last ? '0 : cnt + CW'(1))
            : cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      if (sin_valid) sh <= word;
      cnt  <= cnt_nxt;
      busy <= cnt_nxt != '0;
    end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with one-word valid/ready holding register
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ENC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);
  logic [WIDTH-1:0] word;
  logic done, take;
  sipo_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .word(word), .done(done), .busy(busy)
  );
  // a drain and a completion on the same edge reload without a bubble
  assign take = done & (~dout_valid | dout_ready);
  always_ff @(posedge clk)
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done & dout_valid & ~dout_ready;
      if (take) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) dout_valid <= 1'b0;
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: MSB-first and LSB-first instances checked against a bit-queue model every cycle
module tb_sipo_deser;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, sin = 1'b0, sin_valid = 1'b0, sync = 1'b0, dout_ready = 1'b0;
  logic [W-1:0] dm, dl;
  logic vm, vl, bm, bl, om, ol;
  int tests = 0, fails = 0;
  bit q[$];
  logic [W-1:0] md[2];
  bit mv[2], mo[2], mb;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .dout(dm), .dout_valid(vm), .dout_ready(dout_ready), .busy(bm), .overrun(om)
  );
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .dout(dl), .dout_valid(vl), .dout_ready(dout_ready), .busy(bl), .overrun(ol)
  );

  always #5 clk = ~clk;

  // model: collect accepted bits since the last boundary; a full queue is a word
  always @(posedge clk) begin
    logic [W-1:0] w[2];
    bit comp;
    comp = 0;
    if (!rst_n) begin
      q.delete();
      for (int d = 0; d < 2; d++) begin md[d] = '0; mv[d] = 0; mo[d] = 0; end
    end else begin
      if (sync) q.delete();
      if (sin_valid) begin
        q.push_back(sin);
        if (q.size() == W) begin
          comp = 1;
          for (int i = 0; i < W; i++) begin w[0][W-1-i] = q[i]; w[1][i] = q[i]; end
          q.delete();
        end
      end
      for (int d = 0; d < 2; d++) begin
        mo[d] = 0;
        if (comp) begin
          if (!mv[d] || dout_ready) begin md[d] = w[d]; mv[d] = 1; end
          else mo[d] = 1;
        end else if (mv[d] && dout_ready) mv[d] = 0;
      end
    end
    mb = q.size() != 0;
  end

  always @(negedge clk) begin
    tests += 2;
    if ({dm, vm, bm, om} !== {md[0], mv[0], mb, mo[0]}) begin
      fails++;
      $display("FAIL model_msb t=%0t got dout=%h v=%b busy=%b ovr=%b want dout=%h v=%b busy=%b ovr=%b",
               $time, dm, vm, bm, om, md[0], mv[0], mb, mo[0]);
    end
    if ({dl, vl, bl, ol} !== {md[1], mv[1], mb, mo[1]}) begin
      fails++;
      $display("FAIL model_lsb t=%0t got dout=%h v=%b busy=%b ovr=%b want dout=%h v=%b busy=%b ovr=%b",
               $time, dl, vl, bl, ol, md[1], mv[1], mb, mo[1]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // bits go out in time order seq[7], seq[6], ...; rl is dout_ready during the last bit
  task automatic send(input logic [7:0] seq, input int n, input bit syn, input logic rl);
    for (int i = 0; i < n; i++) begin
      sin = seq[7-i];
      sin_valid = 1'b1;
      sync = (i == 0) && syn;
      if (i == n - 1) dout_ready = rl;
      @(negedge clk);
    end
    sin_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    dout_ready = rdy;
    sin_valid = 1'b0;
    sync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    sin_valid = 1'b1;
    sin = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", {24'd0, dm, vm, bm, om, ol}, 32'd0);
    rst_n = 1'b1;
    send(8'h74, 8, 0, 0);
    check("msb_word", {dm, 7'd0, vm}, {8'h74, 7'd0, 1'b1});
    check("lsb_word_74", dl, 8'h2E);
    idle(1);
    check("drain", {dm, 7'd0, vm}, {8'h74, 8'd0});
    send(8'hC2, 8, 0, 0);
    check("lsb_word", dl, 8'h43);
    check("msb_word_c2", dm, 8'hC2);
    idle(1);
    dout_ready = 1'b0;
    send(8'hE5, 8, 0, 0);
    check("b2b_first", {dm, 7'd0, vm}, {8'hE5, 8'd1});
    send(8'h55, 8, 0, 1);
    check("b2b_second", {dm, 6'd0, vm, om}, {8'h55, 8'd2});
    idle(1);
    dout_ready = 1'b0;
    send(8'hD4, 8, 0, 0);
    send(8'hAD, 8, 0, 0);
    check("ovr_hold", {dm, 6'd0, vm, om}, {8'hD4, 8'd3});
    idle(1);
    check("ovr_after", {dm, 6'd0, vm, om}, {8'hD4, 8'd0});
    dout_ready = 1'b0;
    send(8'hA0, 3, 0, 0);
    check("partial_busy", bm, 1'b1);
    send(8'hF6, 8, 1, 0);
    check("sync_word", {dm, 6'd0, vm, bm}, {8'hF6, 8'd2});
    idle(1);
    send(8'hC1, 5, 0, 1);
    check("mid_busy", bm, 1'b1);
    rst_n = 1'b0;
    idle(0);
    rst_n = 1'b1;
    check("mid_rst", {dm, 5'd0, vm, bm, om}, 16'd0);
    send(8'hAA, 8, 0, 0);
    check("post_rst_word", {dm, dl, 7'd0, om}, {8'hAA, 8'h55, 8'd0});
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(99) != 0;
      sin = 1'($urandom);
      sin_valid = $urandom_range(9) < 7;
      sync = $urandom_range(19) == 0;
      dout_ready = 1'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
